// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register with branch redirect/flush, stall and halt.
// Optional perf counters fetch_cnt/bubble_cnt are built when FETCH_PERF_COUNT_EN is defined.
module fetch_stage #(
  parameter int bus = 4,
  parameter int INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               halt_req,
  input  logic [bus-1:0]     jumpAddress,
  input  logic               NOP,
  output logic [bus-1:0]     imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [bus-1:0]     pc_out,
  output logic               valid_out,
  output logic               halted
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        bubble_cnt
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;
  state_t state_q, state_d;
  logic [bus-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic valid_q, valid_d, halted_q, halted_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pc_out_d = pc_out_q;
    instr_d = instr_q;
    valid_d = valid_q;
    halted_d = halted_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN:
        if (NOP && valid_q) begin
          pc_d = jumpAddress;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = FLUSH;
        end else if (halt_req) begin
          valid_d = 1'b0;
          halted_d = 1'b1;
          state_d = HALT;
        end else if (!stall) begin
          instr_d = imem_data;
          pc_out_d = pc_q;
          valid_d = 1'b1;
          pc_d = pc_q + 1'b1;
        end
      FLUSH: begin
        instr_d = NOP_WORD;
        pc_out_d = pc_q;
        valid_d = 1'b0;
        state_d = RUN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q <= '0;
      pc_out_q <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      halted_q <= halted_d;
    end
  end
  assign imem_addr = pc_q;
  assign instr_out = instr_q;
  assign pc_out = pc_out_q;
  assign valid_out = valid_q;
  assign halted = halted_q;
`ifdef FETCH_PERF_COUNT_EN
  // Counters track IF/ID loads: real fetches vs. redirect/flush bubbles.
  logic load_valid, load_bubble;
  logic [15:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
  assign load_valid = state_q == RUN && !(NOP && valid_q) && !halt_req && !stall;
  assign load_bubble = state_q == FLUSH || (state_q == RUN && NOP && valid_q);
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 16'(load_valid && ~&fetch_cnt_q);
    bubble_cnt_d = bubble_cnt_q + 16'(load_bubble && ~&bubble_cnt_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign fetch_cnt = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan scenarios plus random traffic, scoreboarded against a behavioural model.
module tb_fetch_stage;
  localparam int BW = 4;
  localparam int IW = 16;
  localparam logic [IW-1:0] NW = '0;
  logic clk = 1'b0;
  logic rst, stall, halt_req, nop;
  logic [BW-1:0] jump, imem_addr, pc_out;
  logic [IW-1:0] imem_data, instr_out;
  logic valid_out, halted;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] fetch_cnt, bubble_cnt;
`endif
  logic [IW-1:0] mem [16];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];
  fetch_stage #(.bus(BW), .INSTR_W(IW), .NOP_WORD(NW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .jumpAddress(jump), .NOP(nop), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out), .halted(halted)
`ifdef FETCH_PERF_COUNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  typedef struct packed {
    logic [IW-1:0] instr;
    logic [BW-1:0] pc;
    logic [BW-1:0] addr;
    logic valid;
    logic halted;
    logic [15:0] fc;
    logic [15:0] bc;
  } exp_t;
  exp_t q[$];
  // Reference model: a fetch pointer, the last IF/ID entry, and pending boot/flush/halt conditions.
  int m_pc, m_pco, m_fc, m_bc;
  logic [IW-1:0] m_ins;
  bit m_v, m_h, m_boot, m_flush, live;
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_pco = 0; m_ins = NW; m_v = 0; m_h = 0;
      m_boot = 1; m_flush = 0; m_fc = 0; m_bc = 0; live = 1;
    end else if (live) begin
      if (m_boot) m_boot = 0;
      else if (m_h) ;
      else if (m_flush) begin
        m_flush = 0; m_ins = NW; m_pco = m_pc; m_v = 0;
        m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
      end else if (nop && m_v) begin
        m_ins = NW; m_v = 0; m_pc = int'(jump); m_flush = 1;
        m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
      end else if (halt_req) begin
        m_h = 1; m_v = 0;
      end else if (!stall) begin
        m_ins = mem[m_pc]; m_pco = m_pc; m_v = 1; m_pc = (m_pc + 1) % 16;
        m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
      end
    end
    if (live) q.push_back('{m_ins, BW'(m_pco), BW'(m_pc), m_v, m_h, 16'(m_fc), 16'(m_bc)});
  end
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic bad;
      e = q.pop_front();
      bad = instr_out !== e.instr || pc_out !== e.pc || imem_addr !== e.addr ||
            valid_out !== e.valid || halted !== e.halted;
`ifdef FETCH_PERF_COUNT_EN
      bad = bad || fetch_cnt !== e.fc || bubble_cnt !== e.bc;
`endif
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL scoreboard t=%0t got instr=%h pc=%h addr=%h v=%b h=%b, expected instr=%h pc=%h addr=%h v=%b h=%b fc=%0d bc=%0d",
                 $time, instr_out, pc_out, imem_addr, valid_out, halted,
                 e.instr, e.pc, e.addr, e.valid, e.halted, e.fc, e.bc);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic h, input logic n, input logic [BW-1:0] j);
    rst = r; stall = s; halt_req = h; nop = n; jump = j;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'hA500 | 16'(i);
    cyc(1, 0, 0, 0, 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_pc_out", 32'(pc_out), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_instr", 32'(instr_out), 32'(NW));
    cyc(0, 0, 0, 0, 0);
    chk("boot_valid", 32'(valid_out), 0);
    chk("boot_addr", 32'(imem_addr), 0);
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("run_pc_out", 32'(pc_out), 32'(i % 16));
      chk("run_valid", 32'(valid_out), 1);
      chk("run_instr", 32'(instr_out), 32'(mem[i % 16]));
    end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre_branch_pc", 32'(pc_out), 1);
    cyc(0, 0, 0, 1, 4'b0010);
    chk("redirect_valid", 32'(valid_out), 0);
    chk("redirect_instr", 32'(instr_out), 32'(NW));
    cyc(0, 0, 0, 1, 4'd9);
    chk("flush_valid", 32'(valid_out), 0);
    cyc(0, 0, 0, 0, 0);
    chk("post_branch_pc", 32'(pc_out), 2);
    chk("post_branch_valid", 32'(valid_out), 1);
`ifdef FETCH_PERF_COUNT_EN
    chk("fetch_cnt", 32'(fetch_cnt), 3);
    chk("bubble_cnt", 32'(bubble_cnt), 2);
`endif
    cyc(0, 1, 0, 1, 4'd5);
    chk("stall_nop_addr", 32'(imem_addr), 5);
    chk("stall_nop_valid", 32'(valid_out), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("at5_pc", 32'(pc_out), 5);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0);
      chk("stall_pc", 32'(pc_out), 5);
      chk("stall_valid", 32'(valid_out), 1);
      chk("stall_instr", 32'(instr_out), 32'(mem[5]));
    end
    cyc(0, 0, 0, 0, 0);
    chk("resume_pc", 32'(pc_out), 6);
    cyc(0, 0, 0, 0, 0);
    chk("at7_pc", 32'(pc_out), 7);
    cyc(0, 0, 1, 0, 0);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_valid", 32'(valid_out), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      chk("halt_hold_pc", 32'(pc_out), 7);
      chk("halt_hold_addr", 32'(imem_addr), 8);
      chk("halt_hold_flags", {30'd0, halted, valid_out}, 32'b10);
    end
    cyc(1, 0, 0, 0, 0);
    chk("unhalt_pc", 32'(pc_out), 0);
    chk("unhalt_halted", 32'(halted), 0);
    cyc(0, 0, 0, 0, 0);
    chk("reboot_valid", 32'(valid_out), 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 5) == 0, 4'($urandom));
    cyc(0, 0, 0, 0, 0);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
